pio128_out_arb: RTL and testbench

//  Arbitrates the 128-bit PIO output path between two Avalon-MM write requesters (s0: HPS, s1: DMA).

---
 rtl/pio128_arb_pkg.sv | 22 ++
 rtl/pio128_frame_timer.sv | 44 ++++
 rtl/pio128_out_arb.sv | 161 ++++++++++++++++
 tb/tb_pio128_out_arb.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio128_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pio128_arb_pkg
// Brief    : Shared types and encodings for the 128-bit PIO output arbiter.
// Revision : 1.0
// ============================================================================
package pio128_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_LAST   = 2'd1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pio128_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : pio128_frame_timer
// Brief    : Idle-owner timeout counter; expire is asserted for one cycle.
// Revision : 1.0
// ============================================================================
module pio128_frame_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset, clear, enable};
            assign expire   = 1'b0;
        end else begin : g_enabled
            localparam int TW = $clog2(TIMEOUT_CYC + 1);
            localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT_CYC - 1);

            logic [TW-1:0] r_count;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Fires on the idle cycle that would bring the count to TIMEOUT_CYC.
            assign expire = enable && !clear && (r_count == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pio128_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : pio128_out_arb
// Brief    : Frame-locked two-requester arbiter for the 128-bit PIO output.
// Revision : 1.0
// ============================================================================
module pio128_out_arb
    import pio128_arb_pkg::*;
#(
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_write,
    input  logic [1:0]        s0_address,
    input  logic [DATA_W-1:0] s0_writedata,
    output logic              s0_waitrequest,
    output logic              s0_writeresponsevalid,
    output logic [1:0]        s0_response,
    input  logic              s1_write,
    input  logic [1:0]        s1_address,
    input  logic [DATA_W-1:0] s1_writedata,
    output logic              s1_waitrequest,
    output logic              s1_writeresponsevalid,
    output logic [1:0]        s1_response,
    input  logic              block_read,
    output logic [DATA_W-1:0] pio_out,
    output logic              data_ready,
    output logic [1:0]        grant,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    arb_state_e        r_state;
    logic              r_rr_ptr;
    logic [DATA_W-1:0] r_pio_out;
    logic              r_data_ready;
    logic [1:0]        r_grant;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_s0_rsp_valid;
    logic              r_s1_rsp_valid;
    logic [1:0]        r_s0_response;
    logic [1:0]        r_s1_response;

    logic              w_own0;
    logic              w_own1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_acc;
    logic [1:0]        w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_is_fwd;
    logic              w_is_last;
    logic [1:0]        w_resp;
    logic              w_tmr_clear;
    logic              w_tmr_enable;
    logic              w_expire;

    assign w_own0 = (r_state == OWN0);
    assign w_own1 = (r_state == OWN1);

    assign s0_waitrequest = !w_own0 || block_read;
    assign s1_waitrequest = !w_own1 || block_read;

    assign w_acc0 = s0_write && !s0_waitrequest;
    assign w_acc1 = s1_write && !s1_waitrequest;
    assign w_acc  = w_acc0 || w_acc1;

    // Only the owner can be accepted, so the owner's bus is the one that matters.
    assign w_addr    = w_own1 ? s1_address   : s0_address;
    assign w_wdata   = w_own1 ? s1_writedata : s0_writedata;
    assign w_is_fwd  = (w_addr == ADDR_DATA) || (w_addr == ADDR_LAST);
    assign w_is_last = (w_addr == ADDR_LAST);
    assign w_resp    = w_is_fwd ? RESP_OKAY : RESP_SLVERR;

    assign w_tmr_clear  = (r_state == IDLE) || w_acc;
    assign w_tmr_enable = (w_own0 || w_own1) && !block_read;

    pio128_frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_tmr_clear),
        .enable (w_tmr_enable),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rr_ptr       <= 1'b0;
            r_pio_out      <= '0;
            r_data_ready   <= 1'b0;
            r_grant        <= 2'b00;
            r_timeout_err  <= 1'b0;
            r_frame_cnt    <= '0;
            r_s0_rsp_valid <= 1'b0;
            r_s1_rsp_valid <= 1'b0;
            r_s0_response  <= RESP_OKAY;
            r_s1_response  <= RESP_OKAY;
        end else begin
            r_data_ready   <= 1'b0;
            r_s0_rsp_valid <= w_acc0;
            r_s1_rsp_valid <= w_acc1;
            r_timeout_err  <= w_expire;

            if (w_acc0) r_s0_response <= w_resp;
            if (w_acc1) r_s1_response <= w_resp;

            if (w_acc && w_is_fwd) begin
                r_pio_out    <= w_wdata;
                r_data_ready <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (s0_write && (!s1_write || !r_rr_ptr)) begin
                        r_state <= OWN0;
                        r_grant <= 2'b01;
                    end else if (s1_write) begin
                        r_state <= OWN1;
                        r_grant <= 2'b10;
                    end
                end
                OWN0, OWN1: begin
                    // Priority passes to the other requester whichever way the frame ends.
                    if (w_acc && w_is_last) begin
                        r_state     <= IDLE;
                        r_grant     <= 2'b00;
                        r_rr_ptr    <= w_own0;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end else if (w_expire) begin
                        r_state  <= IDLE;
                        r_grant  <= 2'b00;
                        r_rr_ptr <= w_own0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign pio_out               = r_pio_out;
    assign data_ready            = r_data_ready;
    assign grant                 = r_grant;
    assign timeout_err           = r_timeout_err;
    assign frame_cnt             = r_frame_cnt;
    assign s0_writeresponsevalid = r_s0_rsp_valid;
    assign s1_writeresponsevalid = r_s1_rsp_valid;
    assign s0_response           = r_s0_response;
    assign s1_response           = r_s1_response;

endmodule
`default_nettype wire

// File: tb/tb_pio128_out_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio128_out_arb
// Brief    : Directed and random stimulus for pio128_out_arb against a model.
// Revision : 1.0
// ============================================================================
module tb_pio128_out_arb;
    import pio128_arb_pkg::*;

    localparam int DATA_W = 128;
    localparam int TMO    = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s0_write = 1'b0;
    logic [1:0]        s0_address = '0;
    logic [DATA_W-1:0] s0_writedata = '0;
    logic              s0_waitrequest;
    logic              s0_writeresponsevalid;
    logic [1:0]        s0_response;
    logic              s1_write = 1'b0;
    logic [1:0]        s1_address = '0;
    logic [DATA_W-1:0] s1_writedata = '0;
    logic              s1_waitrequest;
    logic              s1_writeresponsevalid;
    logic [1:0]        s1_response;
    logic              block_read = 1'b0;
    logic [DATA_W-1:0] pio_out;
    logic              data_ready;
    logic [1:0]        grant;
    logic              timeout_err;
    logic [CNT_W-1:0]  frame_cnt;

    always #5 clk = ~clk;

    pio128_out_arb #(
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .s0_write              (s0_write),
        .s0_address            (s0_address),
        .s0_writedata          (s0_writedata),
        .s0_waitrequest        (s0_waitrequest),
        .s0_writeresponsevalid (s0_writeresponsevalid),
        .s0_response           (s0_response),
        .s1_write              (s1_write),
        .s1_address            (s1_address),
        .s1_writedata          (s1_writedata),
        .s1_waitrequest        (s1_waitrequest),
        .s1_writeresponsevalid (s1_writeresponsevalid),
        .s1_response           (s1_response),
        .block_read            (block_read),
        .pio_out               (pio_out),
        .data_ready            (data_ready),
        .grant                 (grant),
        .timeout_err           (timeout_err),
        .frame_cnt             (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner -1 means nobody holds the path.
    int                m_owner;
    int                m_rr;
    int                m_idle;
    logic [CNT_W-1:0]  m_frames;
    logic [DATA_W-1:0] m_pio;
    bit                m_dr;
    bit                m_rv [2];
    logic [1:0]        m_rsp [2];
    bit                m_tmo;

    // Requester intent: a pending write is held on the bus until accepted.
    bit                pend [2];
    logic [1:0]        p_addr [2];
    logic [DATA_W-1:0] p_data [2];
    bit                br;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [1:0] owner_onehot(input int o);
        if (o == 0) return 2'b01;
        if (o == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_rr     = 0;
        m_idle   = 0;
        m_frames = '0;
        m_pio    = '0;
        m_dr     = 1'b0;
        m_rv     = '{1'b0, 1'b0};
        m_rsp    = '{2'b00, 2'b00};
        m_tmo    = 1'b0;
        pend     = '{1'b0, 1'b0};
        br       = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk_v({tag, "_pio_out"}, pio_out, '0);
        chk_b({tag, "_data_ready"}, data_ready, 1'b0);
        chk_v({tag, "_grant"}, DATA_W'(grant), '0);
        chk_b({tag, "_timeout_err"}, timeout_err, 1'b0);
        chk_v({tag, "_frame_cnt"}, DATA_W'(frame_cnt), '0);
        chk_b({tag, "_s0_rv"}, s0_writeresponsevalid, 1'b0);
        chk_b({tag, "_s1_rv"}, s1_writeresponsevalid, 1'b0);
        chk_v({tag, "_s0_resp"}, DATA_W'(s0_response), '0);
        chk_v({tag, "_s1_resp"}, DATA_W'(s1_response), '0);
    endtask

    task automatic drive_idle_bus();
        s0_write   = 1'b0;
        s1_write   = 1'b0;
        block_read = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        drive_idle_bus();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_zero_outputs("reset");
    endtask

    task automatic post(input int n, input logic [1:0] a, input logic [DATA_W-1:0] d);
        pend[n]   = 1'b1;
        p_addr[n] = a;
        p_data[n] = d;
    endtask

    // One clock: drive, predict from the arbitration rules, then compare.
    task automatic cycle();
        bit acc [2];
        s0_write     = pend[0];
        s0_address   = p_addr[0];
        s0_writedata = p_data[0];
        s1_write     = pend[1];
        s1_address   = p_addr[1];
        s1_writedata = p_data[1];
        block_read   = br;
        #1;
        chk_b("s0_waitrequest", s0_waitrequest, (m_owner != 0) || br);
        chk_b("s1_waitrequest", s1_waitrequest, (m_owner != 1) || br);

        m_dr  = 1'b0;
        m_tmo = 1'b0;
        for (int n = 0; n < 2; n++) begin
            acc[n]  = pend[n] && (m_owner == n) && !br;
            m_rv[n] = acc[n];
            if (acc[n]) begin
                m_rsp[n] = (p_addr[n] <= 2'd1) ? 2'b00 : 2'b10;
                if (p_addr[n] <= 2'd1) begin
                    m_pio = p_data[n];
                    m_dr  = 1'b1;
                end
            end
        end

        if (m_owner < 0) begin
            if (pend[0] && (!pend[1] || m_rr == 0)) m_owner = 0;
            else if (pend[1]) m_owner = 1;
            m_idle = 0;
        end else if (acc[m_owner]) begin
            m_idle = 0;
            if (p_addr[m_owner] == 2'd1) begin
                m_rr     = (m_owner == 0) ? 1 : 0;
                m_frames = m_frames + 1'b1;
                m_owner  = -1;
            end
        end else if (!br) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_rr    = (m_owner == 0) ? 1 : 0;
                m_tmo   = 1'b1;
                m_owner = -1;
                m_idle  = 0;
            end
        end
        for (int n = 0; n < 2; n++) if (acc[n]) pend[n] = 1'b0;

        @(posedge clk);
        #1;
        chk_v("grant", DATA_W'(grant), DATA_W'(owner_onehot(m_owner)));
        chk_v("pio_out", pio_out, m_pio);
        chk_b("data_ready", data_ready, m_dr);
        chk_b("timeout_err", timeout_err, m_tmo);
        chk_v("frame_cnt", DATA_W'(frame_cnt), DATA_W'(m_frames));
        chk_b("s0_rv", s0_writeresponsevalid, m_rv[0]);
        chk_b("s1_rv", s1_writeresponsevalid, m_rv[1]);
        if (m_rv[0]) chk_v("s0_response", DATA_W'(s0_response), DATA_W'(m_rsp[0]));
        if (m_rv[1]) chk_v("s1_response", DATA_W'(s1_response), DATA_W'(m_rsp[1]));
    endtask

    task automatic run_acc(input int n);
        for (int i = 0; i < 40 && pend[n]; i++) cycle();
    endtask

    task automatic run_all();
        for (int i = 0; i < 80 && (pend[0] || pend[1]); i++) cycle();
    endtask

    initial begin
        logic [DATA_W-1:0] w_a0;
        logic [DATA_W-1:0] w_a1;
        logic [DATA_W-1:0] w_dead;
        int                r;

        w_a0   = rnd_word();
        w_a1   = rnd_word();
        w_dead = {32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        // Two-word frame from s0.
        reset_dut();
        post(0, 2'd0, w_a0);
        cycle();
        chk_v("t1_grant_own0", DATA_W'(grant), DATA_W'(2'b01));
        cycle();
        chk_v("t1_pio_a0", pio_out, w_a0);
        chk_b("t1_dr_a0", data_ready, 1'b1);
        post(0, 2'd1, w_a1);
        cycle();
        chk_v("t1_pio_a1", pio_out, w_a1);
        chk_v("t1_frame_cnt", DATA_W'(frame_cnt), DATA_W'(16'd1));
        chk_v("t1_grant_idle", DATA_W'(grant), '0);

        // Simultaneous one-word frames, s0 wins with rr_ptr=0.
        reset_dut();
        post(0, 2'd1, w_a0);
        post(1, 2'd1, w_a1);
        cycle();
        chk_v("t2_grant_s0_first", DATA_W'(grant), DATA_W'(2'b01));
        cycle();
        cycle();
        chk_v("t2_grant_s1_second", DATA_W'(grant), DATA_W'(2'b10));
        cycle();
        chk_v("t2_pio_s1", pio_out, w_a1);
        chk_v("t2_frame_cnt", DATA_W'(frame_cnt), DATA_W'(16'd2));

        // Long downstream stall mid-frame must not trip the timeout.
        post(0, 2'd0, rnd_word());
        run_acc(0);
        post(0, 2'd1, w_a0);
        br = 1'b1;
        repeat (50) cycle();
        chk_v("t3_grant_held", DATA_W'(grant), DATA_W'(2'b01));
        chk_b("t3_owner_stalled", s0_waitrequest, 1'b1);
        br = 1'b0;
        run_acc(0);
        chk_v("t3_frame_cnt", DATA_W'(frame_cnt), DATA_W'(16'd3));

        // s1 goes quiet after one data word.
        post(1, 2'd0, w_a1);
        run_acc(1);
        for (int i = 1; i <= TMO; i++) begin
            cycle();
            chk_b("t4_timeout_pulse", timeout_err, i == TMO);
        end
        chk_v("t4_grant_revoked", DATA_W'(grant), '0);
        chk_v("t4_frame_unchanged", DATA_W'(frame_cnt), DATA_W'(16'd3));
        post(0, 2'd1, rnd_word());
        post(1, 2'd1, rnd_word());
        cycle();
        chk_v("t4_rr_points_s0", DATA_W'(grant), DATA_W'(2'b01));
        run_all();

        // Reserved address gets SLVERR and forwards nothing.
        post(0, 2'd0, w_a0);
        run_acc(0);
        post(0, 2'd2, w_a1);
        run_acc(0);
        chk_v("t5_slverr", DATA_W'(s0_response), DATA_W'(2'b10));
        chk_b("t5_no_data_ready", data_ready, 1'b0);
        chk_v("t5_pio_unchanged", pio_out, w_a0);
        chk_v("t5_grant_kept", DATA_W'(grant), DATA_W'(2'b01));
        post(0, 2'd1, w_a1);
        run_acc(0);

        // Asynchronous reset while a word is being presented.
        post(0, 2'd0, w_dead);
        run_acc(0);
        chk_b("t6_dr_before_reset", data_ready, 1'b1);
        #2;
        reset = 1'b1;
        drive_idle_bus();
        #1;
        check_zero_outputs("t6_async");
        #2;
        reset = 1'b0;
        model_reset();
        post(1, 2'd1, w_a1);
        cycle();
        chk_v("t6_grant_s1", DATA_W'(grant), DATA_W'(2'b10));
        run_acc(1);
        chk_v("t6_frame_cnt", DATA_W'(frame_cnt), DATA_W'(16'd1));

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && $urandom_range(99) < 35) begin
                    r = $urandom_range(19);
                    if (r < 10)      post(n, 2'd0, rnd_word());
                    else if (r < 16) post(n, 2'd1, rnd_word());
                    else             post(n, 2'(2 + (r % 2)), rnd_word());
                end
            end
            br = ($urandom_range(9) < 2);
            cycle();
        end
        br = 1'b0;
        run_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
